// File: rtl/mult_accum_stage.sv
// rtl/mult_accum_stage.sv - registered, back-pressurable MAC accumulator behind the 32x32 multiplier
//
// Purpose: sums BURST_LEN unsigned products into an ACC_W-bit accumulator and
// presents the total with a sticky overflow flag on a valid/ready output.
// Optional feature macro: MULT_ACCUM_SATURATE_EN (clamp on carry-out instead of wrap).
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_in_valid/o_in_ready product beat handshake
//   i_prod, i_prod_ovf    product (zero-extended to ACC_W) and multiplier overflow flag
//   i_acc_clear           synchronous abort/clear, highest priority after reset
//   o_out_valid/i_out_ready result handshake
//   o_out_acc, o_out_ovf  accumulated sum and sticky overflow
//   o_beat_cnt            beats accepted in the current burst
module mult_accum_stage #(
  parameter int PROD_W    = 64,
  parameter int ACC_W     = 72,
  parameter int BURST_LEN = 8,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_prod,
  input  logic              i_prod_ovf,
  input  logic              i_acc_clear,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_acc,
  output logic              o_out_ovf,
  output logic [CNT_W-1:0]  o_beat_cnt
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic               w_accept;
  logic               w_last_beat;
  logic               w_drain_done;
  logic [SUM_W-1:0]   w_sum;
  logic               w_carry;
  logic [ACC_W-1:0]   w_acc_nxt;

  assign o_in_ready   = (r_state == ST_ACCUM) && !i_acc_clear;
  assign o_out_valid  = (r_state == ST_DRAIN);
  assign o_out_acc    = r_acc;
  assign o_out_ovf    = r_ovf;
  assign o_beat_cnt   = r_beat_cnt;

  assign w_accept     = i_in_valid && o_in_ready;
  assign w_last_beat  = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
  assign w_drain_done = o_out_valid && i_out_ready;

  // One extra bit on the adder exposes the carry-out that feeds the sticky flag.
  assign w_sum   = {1'b0, r_acc} + SUM_W'(i_prod);
  assign w_carry = w_sum[ACC_W];

`ifdef MULT_ACCUM_SATURATE_EN
  // Once clamped, any further non-zero product carries out again and re-clamps.
  assign w_acc_nxt = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_acc_clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && w_last_beat) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (w_drain_done) w_state_nxt = ST_ACCUM;
        default:  w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  // Accept is only possible in ACCUM without clear, drain-done only in DRAIN,
  // so the last two branches never compete.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_beat_cnt <= '0;
    end else if (i_acc_clear || w_drain_done) begin
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_acc      <= w_acc_nxt;
      r_ovf      <= r_ovf | i_prod_ovf | w_carry;
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mult_accum_stage.sv
// tb/tb_mult_accum_stage.sv - self-checking bench for mult_accum_stage
module tb_mult_accum_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] prod;
  logic        prod_ovf;
  logic        acc_clear;
  logic        out_ready;
  logic        use2;

  logic        in_ready1, out_valid1, out_ovf1;
  logic [71:0] out_acc1;
  logic [3:0]  beat_cnt1;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [65:0] out_acc2;
  logic [3:0]  beat_cnt2;

  logic        m_in_ready, m_out_valid, m_out_ovf;
  logic [71:0] m_out_acc;
  logic [3:0]  m_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] bp[8];
  bit          bo[8];

  always #5 clk = ~clk;

  mult_accum_stage u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid & ~use2), .o_in_ready(in_ready1),
    .i_prod(prod), .i_prod_ovf(prod_ovf), .i_acc_clear(acc_clear),
    .o_out_valid(out_valid1), .i_out_ready(out_ready & ~use2),
    .o_out_acc(out_acc1), .o_out_ovf(out_ovf1), .o_beat_cnt(beat_cnt1)
  );

  mult_accum_stage #(.ACC_W(66)) u_dut66 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid & use2), .o_in_ready(in_ready2),
    .i_prod(prod), .i_prod_ovf(prod_ovf), .i_acc_clear(acc_clear),
    .o_out_valid(out_valid2), .i_out_ready(out_ready & use2),
    .o_out_acc(out_acc2), .o_out_ovf(out_ovf2), .o_beat_cnt(beat_cnt2)
  );

  assign m_in_ready  = use2 ? in_ready2  : in_ready1;
  assign m_out_valid = use2 ? out_valid2 : out_valid1;
  assign m_out_ovf   = use2 ? out_ovf2   : out_ovf1;
  assign m_out_acc   = use2 ? {6'b0, out_acc2} : out_acc1;
  assign m_cnt       = use2 ? beat_cnt2  : beat_cnt1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input logic [63:0] p, input bit o);
    int budget;
    budget   = 20;
    in_valid = 1'b1;
    prod     = p;
    prod_ovf = o;
    #1;
    while (!m_in_ready && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    chk("accept_timeout", 128'(budget > 0), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    prod_ovf = 1'b0;
    #1;
  endtask

  // Reference result: exact sum of the burst, then wrap or clamp to the accumulator width.
  task automatic model(output logic [127:0] exp_acc, output bit exp_ovf);
    logic [127:0] tot, lim;
    int w;
    w       = use2 ? 66 : 72;
    lim     = 128'd1 << w;
    tot     = '0;
    exp_ovf = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tot     += 128'(bp[i]);
      exp_ovf |= bo[i];
    end
    if (tot >= lim) exp_ovf = 1'b1;
`ifdef MULT_ACCUM_SATURATE_EN
    exp_acc = (tot >= lim) ? lim - 1 : tot;
`else
    exp_acc = tot & (lim - 1);
`endif
  endtask

  task automatic run_burst(input int hold, input bit gaps);
    logic [127:0] exp_acc;
    bit exp_ovf;
    model(exp_acc, exp_ovf);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      send(bp[i], bo[i]);
      chk("beat_cnt", 128'(m_cnt), 128'(i + 1));
      chk("out_valid_burst", 128'(m_out_valid), 128'(i == 7));
    end
    chk("out_acc", 128'(m_out_acc), exp_acc);
    chk("out_ovf", 128'(m_out_ovf), 128'(exp_ovf));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      prod     = {$urandom, $urandom};
      @(negedge clk); #1;
      chk("hold_valid", 128'(m_out_valid), 128'd1);
      chk("hold_ready", 128'(m_in_ready), 128'd0);
      chk("hold_acc", 128'(m_out_acc), exp_acc);
      chk("hold_cnt", 128'(m_cnt), 128'd8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", 128'(m_in_ready), 128'd0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("post_valid", 128'(m_out_valid), 128'd0);
    chk("post_in_ready", 128'(m_in_ready), 128'd1);
    chk("post_acc", 128'(m_out_acc), 128'd0);
    chk("post_ovf", 128'(m_out_ovf), 128'd0);
    chk("post_cnt", 128'(m_cnt), 128'd0);
  endtask

  initial begin
    use2      = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'($urandom_range(0, 1));
    prod      = {$urandom, $urandom};
    prod_ovf  = 1'($urandom_range(0, 1));
    acc_clear = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0; prod_ovf = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 128'(m_out_valid), 128'd0);
    chk("rst_in_ready", 128'(m_in_ready), 128'd1);
    chk("rst_cnt", 128'(m_cnt), 128'd0);
    chk("rst_acc", 128'(m_out_acc), 128'd0);

    // Asynchronous reset mid-burst, observed before any clock edge.
    for (int i = 0; i < 3; i++) send(64'd9, 1'b1);
    chk("pre_arst_acc", 128'(m_out_acc), 128'd27);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", 128'(m_out_acc), 128'd0);
    chk("arst_cnt", 128'(m_cnt), 128'd0);
    chk("arst_ovf", 128'(m_out_ovf), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal burst.
    for (int i = 0; i < 8; i++) begin bp[i] = 64'd100; bo[i] = 1'b0; end
    run_burst(0, 1'b0);
    chk("nominal_ref", 128'd800, 128'(8 * 100));

    // Back-pressure with prod = 1..8.
    for (int i = 0; i < 8; i++) begin bp[i] = 64'(i + 1); bo[i] = 1'b0; end
    run_burst(5, 1'b0);

    // Clear mid-burst; the clear-cycle beat must not count.
    for (int i = 0; i < 3; i++) send(64'd7, 1'b0);
    acc_clear = 1'b1; in_valid = 1'b1; prod = 64'd7;
    #1;
    chk("clear_in_ready", 128'(m_in_ready), 128'd0);
    @(negedge clk);
    acc_clear = 1'b0; in_valid = 1'b0;
    #1;
    chk("clear_acc", 128'(m_out_acc), 128'd0);
    chk("clear_cnt", 128'(m_cnt), 128'd0);
    for (int i = 0; i < 8; i++) begin bp[i] = 64'd5; bo[i] = 1'b0; end
    run_burst(1, 1'b0);

    // Clear while a result is pending discards it.
    for (int i = 0; i < 8; i++) send(64'd2, 1'b0);
    chk("pend_valid", 128'(m_out_valid), 128'd1);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    #1;
    chk("discard_valid", 128'(m_out_valid), 128'd0);
    chk("discard_acc", 128'(m_out_acc), 128'd0);
    chk("discard_ready", 128'(m_in_ready), 128'd1);

    // prod_ovf on beat 4 only, then a clean burst.
    for (int i = 0; i < 8; i++) begin bp[i] = 64'd1; bo[i] = (i == 3); end
    run_burst(0, 1'b0);
    for (int i = 0; i < 8; i++) bo[i] = 1'b0;
    run_burst(0, 1'b0);

    // Randomized bursts on the default instance.
    for (int b = 0; b < 5; b++) begin
      for (int i = 0; i < 8; i++) begin
        bp[i] = {$urandom, $urandom};
        bo[i] = ($urandom_range(0, 7) == 0);
      end
      run_burst($urandom_range(0, 3), 1'b1);
    end

    // Narrow accumulator: carry-out of the add.
    use2 = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin bp[i] = 64'hFFFF_FFFF_FFFF_FFFF; bo[i] = 1'b0; end
    run_burst(2, 1'b0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) begin
        bp[i] = {$urandom, $urandom} | 64'hC000_0000_0000_0000;
        bo[i] = 1'b0;
      end
      run_burst(1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
